// File: rtl/reg_dump_unit.sv
// reg_dump_unit: reads NUM_REGS words from a register bank with one cycle of
// read latency and streams each word MSB byte first over a valid/ready link.
// A dump starts from IDLE on start=1 and ends with a one-cycle done pulse.
module reg_dump_unit #(
  parameter int NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [4:0]  rdAddr,
  input  logic [31:0] rdData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [4:0]  regIdx_q;
  logic [1:0]  byteIdx_q;
  logic [31:0] shift_q;
  logic        txValid_q;
  logic        busy_q;
  logic        done_q;

  // The bank address is the register counter itself, so it only moves on posedge.
  assign rdAddr  = regIdx_q;
  // The outgoing byte is always the top of the shift register.
  assign txData  = shift_q[31:24];
  assign txValid = txValid_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Dump sequencer: state, counters, shift register and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      regIdx_q  <= 5'd0;
      byteIdx_q <= 2'd0;
      shift_q   <= 32'd0;
      txValid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            regIdx_q <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= S_WAIT;
          end
        end
        // The bank samples rdAddr at the end of this cycle.
        S_WAIT: begin
          state_q <= S_CAPTURE;
        end
        // rdData now reflects the address presented during WAIT.
        S_CAPTURE: begin
          shift_q   <= rdData;
          byteIdx_q <= 2'd0;
          txValid_q <= 1'b1;
          state_q   <= S_SEND;
        end
        // Hold the byte until accepted; after the fourth byte move to the
        // next register or finish.
        S_SEND: begin
          if (txReady) begin
            if (byteIdx_q != 2'd3) begin
              shift_q   <= {shift_q[23:0], 8'd0};
              byteIdx_q <= byteIdx_q + 2'd1;
            end else if (regIdx_q != LAST_IDX) begin
              regIdx_q  <= regIdx_q + 5'd1;
              txValid_q <= 1'b0;
              state_q   <= S_WAIT;
            end else begin
              txValid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        // start is ignored here; a new dump must be requested from IDLE.
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          txValid_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of registers dumped (legal range 1..32).
REQ-002 The block SHALL have port clock, input, 1, the single clock; every flop updates on posedge only.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a level sampled each posedge that requests a dump; it is ignored unless in IDLE.
REQ-005 The block SHALL have port rdAddr, output, 5, the register-bank read address.
REQ-006 The block SHALL have port rdData, input, 32, the register-bank read data, registered inside the bank on posedge from rdAddr, so it is valid one cycle after rdAddr.
REQ-007 The block SHALL have port txData, output, 8, the byte offered to the downstream transmitter.
REQ-008 The block SHALL have port txValid, output, 1, high when txData holds a byte.
REQ-009 The block SHALL have port txReady, input, 1, downstream acceptance; a byte transfers on a posedge where txValid and txReady are both 1.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when a dump completes.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT, CAPTURE, SEND and DONE, with regIdx (5b) and byteIdx (2b) counters and a 32b shift register.
REQ-013 IDLE with start=1 SHALL clear regIdx to 0 and go to WAIT; start=1 in any other state SHALL have no effect.
REQ-014 rdAddr SHALL equal regIdx at all times, changing only on posedge.
REQ-015 WAIT SHALL last exactly one cycle and go to CAPTURE (bank samples rdAddr).
REQ-016 CAPTURE SHALL load the shift register with rdData, clear byteIdx, and go to SEND.
REQ-017 SEND SHALL drive txValid=1 and txData=shift[31:24], sending each word big-endian, MSB byte first.
REQ-018 In SEND, txData SHALL be held stable while txValid=1 and txReady=0, with no timeout.
REQ-019 On a transfer with byteIdx<3, the block SHALL shift the register left by 8, increment byteIdx, and stay in SEND.
REQ-020 On a transfer with byteIdx=3 and regIdx<NUM_REGS-1, the block SHALL increment regIdx and go to WAIT.
REQ-021 On a transfer with byteIdx=3 and regIdx=NUM_REGS-1, the block SHALL go to DONE.
REQ-022 DONE SHALL assert done=1 for one cycle and then go to IDLE; start=1 in DONE is ignored, so a new dump needs start high in IDLE.
REQ-023 txValid SHALL be 0 outside SEND, and txData is don't-care while txValid=0.
REQ-024 With txReady held at 1, a dump SHALL take 6*NUM_REGS cycles from start acceptance to DONE entry; the first txValid is 2 cycles after acceptance.
REQ-025 The block SHALL never write the register bank; no wrap of regIdx past NUM_REGS-1 is permitted.

Reset
REQ-026 reset_n=0 SHALL immediately, without a clock, force IDLE, regIdx=0, byteIdx=0, shift=0, rdAddr=0, txValid=0, txData=0, busy=0 and done=0.
REQ-027 Reset asserted mid-dump SHALL abort the dump with no done pulse, and a partially sent word is not resumed.
REQ-028 After reset_n rises, the block SHALL accept start on the first posedge.

Verification
REQ-029 Bank preloaded reg[i]=0x01020300+i, txReady=1, one start pulse -> 128 bytes 01 02 03 00, 01 02 03 01 ... 01 02 03 1F in order; done at cycle 192 after acceptance; busy high throughout.
REQ-030 Random txReady stalls (50%) with reg[5]=0xDEADBEEF -> byte stream identical to REQ-029 ordering with reg5 bytes DE AD BE EF; txData is stable across every stall and no byte is duplicated or dropped.
REQ-031 start held high for the whole dump -> exactly one dump, done pulses once, and a second dump starts only after the IDLE cycle following DONE.
REQ-032 reset_n pulsed low while the third byte of reg 7 is pending -> txValid, busy and rdAddr are 0 asynchronously, no done pulse occurs, and the next start dumps from reg 0.
REQ-033 NUM_REGS=1, reg0=0x00000000 -> bytes 00 00 00 00, then done; rdAddr never leaves 0.
REQ-034 The bench SHALL check rdAddr against the read-latency model: rdData captured in CAPTURE equals bank[rdAddr] set in the preceding WAIT for every register.
